// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/CS/MOSI, exchanges one 8..32-bit word
// per chip-select in any CPOL/CPHA mode.
module spi_slave #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SCLK,
   input  logic        CS,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [31:0] tx_data,
   output logic [31:0] rx_data,
   input  logic [1:0]  transaction_length,
   input  logic        CPOL,
   input  logic        CPHA,
   input  logic        default_val,
   output logic        busy,
   output logic        rx_valid,
   output logic        abort
);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_hist;
   logic                   cs_hist;

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall;
   logic cs_rise, cs_fall;

   logic [2:0]  flush_cnt;
   logic        cs_armed;
   logic        cs_go;

   logic [31:0] tx_lat;
   logic [1:0]  len_lat;
   logic        cpol_lat;
   logic        cpha_lat;
   logic [30:0] rx_shift;
   logic [5:0]  rx_cnt;
   logic [4:0]  tx_idx;
   logic        lead_seen;

   logic        lead_edge, trail_edge;
   logic        sample_edge, shift_edge;
   logic [5:0]  n_bits;
   logic [31:0] rx_next;
   logic        last_bit;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_hist <= 1'b0;
         cs_hist   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         sclk_hist <= sclk_sync[SYNC_STAGES-1];
         cs_hist   <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_hist;
   assign sclk_fall = ~sclk_s & sclk_hist;
   assign cs_rise   = cs_s & ~cs_hist;
   assign cs_fall   = ~cs_s & cs_hist;

   // A CS held low across reset shows up as a fall once the chain
   // flushes; only trust CS after it has been seen high post-flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_cnt <= '0;
         cs_armed  <= 1'b0;
      end else begin
         if (flush_cnt != 3'(SYNC_STAGES + 1))
            flush_cnt <= flush_cnt + 3'd1;
         if (flush_cnt == 3'(SYNC_STAGES + 1) && cs_s)
            cs_armed <= 1'b1;
      end
   end

   assign cs_go = cs_fall & cs_armed;

   assign lead_edge   = cpol_lat ? sclk_fall : sclk_rise;
   assign trail_edge  = cpol_lat ? sclk_rise : sclk_fall;
   assign sample_edge = cpha_lat ? trail_edge : lead_edge;
   assign shift_edge  = cpha_lat ? lead_edge : trail_edge;
   assign n_bits      = 6'({len_lat, 3'b000}) + 6'd8;
   assign rx_next     = {rx_shift, mosi_s};
   assign last_bit    = (state == ACTIVE) && sample_edge &&
                        (rx_cnt + 6'd1 == n_bits);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (cs_go) state_nxt = ACTIVE;
         end
         ACTIVE: begin
            if (last_bit)     state_nxt = cs_rise ? IDLE : DONE;
            else if (cs_rise) state_nxt = IDLE;
         end
         DONE: begin
            if (cs_rise) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         abort     <= 1'b0;
         tx_lat    <= '0;
         len_lat   <= '0;
         cpol_lat  <= 1'b0;
         cpha_lat  <= 1'b0;
         rx_shift  <= '0;
         rx_cnt    <= '0;
         tx_idx    <= '0;
         lead_seen <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         abort    <= 1'b0;
         if (state == IDLE && cs_go) begin
            tx_lat    <= tx_data;
            len_lat   <= transaction_length;
            cpol_lat  <= CPOL;
            cpha_lat  <= CPHA;
            rx_shift  <= '0;
            rx_cnt    <= '0;
            tx_idx    <= {transaction_length, 3'b111};
            lead_seen <= 1'b0;
         end
         if (state == ACTIVE) begin
            if (sample_edge) begin
               rx_shift <= rx_next[30:0];
               rx_cnt   <= rx_cnt + 6'd1;
            end
            if (last_bit) begin
               rx_data  <= rx_next;
               rx_valid <= 1'b1;
            end else if (cs_rise) begin
               abort <= 1'b1;
            end
            // CPHA=1 puts the MSB out on the first leading edge
            if (shift_edge) begin
               if (!cpha_lat || lead_seen)
                  tx_idx <= tx_idx - 5'd1;
               lead_seen <= 1'b1;
            end
         end
      end
   end

   assign busy = (state != IDLE);

   always_comb begin
      MISO = default_val;
      if (!rst && state != IDLE) begin
         if (!cpha_lat || lead_seen)
            MISO = tx_lat[tx_idx];
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged SPI master plus word-level model
// of what each side must receive.
module tb_spi_slave;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        SCLK, CS, MOSI, MISO;
   logic [31:0] tx_data, rx_data;
   logic [1:0]  transaction_length;
   logic        CPOL, CPHA, default_val;
   logic        busy, rx_valid, abort;

   int checks = 0;
   int errors = 0;
   int nvalid = 0;
   int nabort = 0;
   logic [31:0] model_rx = '0;
   logic [31:0] prev_rx = '0;
   logic        prev_rst = 1'b1;
   logic [31:0] last_got;

   spi_slave #(.SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
      .MISO(MISO), .tx_data(tx_data), .rx_data(rx_data),
      .transaction_length(transaction_length), .CPOL(CPOL),
      .CPHA(CPHA), .default_val(default_val), .busy(busy),
      .rx_valid(rx_valid), .abort(abort)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic waitn(input int k);
      repeat (k) @(negedge clk);
   endtask

   function automatic logic [31:0] mask(input int n);
      logic [63:0] m;
      m = (64'd1 << n) - 64'd1;
      return m[31:0];
   endfunction

   // Per-cycle invariants: pulse accounting, rx_data only moves with
   // rx_valid, MISO idles at default_val whenever not busy.
   always begin
      @(negedge clk);
      #1;
      if (!rst && !prev_rst) begin
         if (rx_valid) nvalid++;
         if (abort) nabort++;
         if (!rx_valid) chk("rx_hold", rx_data, prev_rx);
         chk("pulse_excl", 32'(rx_valid & abort), 32'd0);
         if (!busy) chk("idle_miso", 32'(MISO), 32'(default_val));
      end
      prev_rx  = rx_data;
      prev_rst = rst;
   end

   task automatic txn(input bit cpol_i, input bit cpha_i,
                      input bit [1:0] len_i, input logic [31:0] mosi_w,
                      input logic [31:0] tx_w, input int stop_bits,
                      input int extra, input bit dv);
      int n, h, nb, v0, a0, bad;
      bit complete;
      logic [31:0] got;
      logic b;
      n   = 8 * (int'(len_i) + 1);
      h   = $urandom_range(S + 3, S + 7);
      nb  = stop_bits + extra;
      v0  = nvalid;
      a0  = nabort;
      bad = 0;
      got = '0;
      complete = (stop_bits >= n);
      default_val = dv;
      CPOL = cpol_i;
      CPHA = cpha_i;
      transaction_length = len_i;
      tx_data = tx_w;
      SCLK = cpol_i;
      waitn(h);
      CS = 1'b0;
      if (!cpha_i) MOSI = mosi_w[n-1];
      waitn(h);
      if (cpha_i) chk("pre_lead_miso", 32'(MISO), 32'(dv));
      for (int i = 0; i < nb; i++) begin
         b = (i < n) ? mosi_w[n-1-i] : 1'($urandom);
         if (!cpha_i) begin
            if (i < n) got = {got[30:0], MISO};
            else if (MISO !== tx_w[0]) bad++;
         end else begin
            MOSI = b;
         end
         SCLK = ~cpol_i;
         waitn(h);
         if (i == 0) begin
            chk("busy_mid", 32'(busy), 32'd1);
            tx_data = $urandom;
            transaction_length = 2'($urandom);
            CPOL = 1'($urandom);
            CPHA = 1'($urandom);
         end
         if (cpha_i) begin
            if (i < n) got = {got[30:0], MISO};
            else if (MISO !== tx_w[0]) bad++;
         end else begin
            MOSI = (i + 1 < n) ? mosi_w[n-2-i] : 1'($urandom);
         end
         SCLK = cpol_i;
         waitn(h);
      end
      CS = 1'b1;
      MOSI = 1'b0;
      waitn(S + 4);
      if (complete) model_rx = mosi_w & mask(n);
      last_got = got;
      chk("busy_end", 32'(busy), 32'd0);
      chk("rx_valid_cnt", nvalid - v0, complete ? 32'd1 : 32'd0);
      chk("abort_cnt", nabort - a0, complete ? 32'd0 : 32'd1);
      chk("rx_data", rx_data, model_rx);
      if (complete) chk("miso_word", got & mask(n), tx_w & mask(n));
      if (extra > 0) chk("done_miso_hold", bad, 32'd0);
   endtask

   initial begin
      int h, v0, a0, n, stop, extra;
      bit [1:0] len;
      rst = 1'b1;
      SCLK = 1'b0;
      CS = 1'b1;
      MOSI = 1'b0;
      tx_data = '0;
      transaction_length = '0;
      CPOL = 1'b0;
      CPHA = 1'b0;
      default_val = 1'b1;
      waitn(3);
      chk("rst_rx_data", rx_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      chk("rst_miso", 32'(MISO), 32'd1);
      rst = 1'b0;
      waitn(S + 4);

      txn(1'b1, 1'b0, 2'd0, 32'hCA, 32'hF2, 8, 0, 1'b0);
      chk("t1_rx", rx_data, 32'h0000_00CA);
      chk("t1_miso", last_got, 32'h0000_00F2);

      txn(1'b1, 1'b0, 2'd3, 32'h9602_C5CA, 32'h1234_5678, 32, 0, 1'b1);
      chk("t2_rx", rx_data, 32'h9602_C5CA);
      chk("t2_miso", last_got, 32'h1234_5678);

      for (int m = 0; m < 4; m++) begin
         txn(m[1], m[0], 2'd1, 32'hA55A, 32'h3CC3, 16, 0, m[0]);
         chk("t3_rx", rx_data, 32'h0000_A55A);
         chk("t3_miso", last_got, 32'h0000_3CC3);
      end

      txn(1'b0, 1'b0, 2'd2, 32'h0013_5799, 32'h0024_6800, 10, 0, 1'b0);
      chk("t4_abort_rx", rx_data, 32'h0000_A55A);
      txn(1'b0, 1'b1, 2'd2, 32'hABCDEF, 32'h00FE_DCBA, 24, 0, 1'b1);
      chk("t4_rx", rx_data, 32'h00AB_CDEF);
      chk("t4_miso", last_got, 32'h00FE_DCBA);

      h = S + 4;
      default_val = 1'b1;
      CPOL = 1'b0;
      CPHA = 1'b0;
      transaction_length = 2'd0;
      tx_data = 32'hFF;
      SCLK = 1'b0;
      waitn(h);
      CS = 1'b0;
      MOSI = 1'b1;
      waitn(h);
      repeat (3) begin
         SCLK = 1'b1; waitn(h);
         SCLK = 1'b0; waitn(h);
      end
      rst = 1'b1;
      waitn(1);
      chk("t5_rx_data", rx_data, 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_rx_valid", 32'(rx_valid), 32'd0);
      chk("t5_abort", 32'(abort), 32'd0);
      chk("t5_miso", 32'(MISO), 32'd1);
      waitn(1);
      rst = 1'b0;
      model_rx = '0;
      v0 = nvalid;
      a0 = nabort;
      repeat (10) begin
         MOSI = 1'($urandom);
         SCLK = 1'b1; waitn(h);
         SCLK = 1'b0; waitn(h);
      end
      chk("t5_ignored_busy", 32'(busy), 32'd0);
      chk("t5_ignored_valid", nvalid - v0, 32'd0);
      chk("t5_ignored_abort", nabort - a0, 32'd0);
      CS = 1'b1;
      waitn(h);
      txn(1'b0, 1'b0, 2'd0, 32'h5E, 32'hA7, 8, 0, 1'b1);
      chk("t5_rx", rx_data, 32'h0000_005E);
      chk("t5_miso", last_got, 32'h0000_00A7);

      txn(1'b0, 1'b0, 2'd0, 32'h3C, 32'h81, 8, 12, 1'b0);
      chk("t6_rx", rx_data, 32'h0000_003C);
      txn(1'b1, 1'b1, 2'd0, 32'hC3, 32'h7E, 8, 12, 1'b1);
      chk("t6b_rx", rx_data, 32'h0000_00C3);

      for (int k = 0; k < 24; k++) begin
         len = 2'($urandom);
         n = 8 * (int'(len) + 1);
         stop = ($urandom_range(0, 4) == 0) ? $urandom_range(1, n - 1) : n;
         extra = (stop == n && $urandom_range(0, 3) == 0) ?
                 $urandom_range(1, 4) : 0;
         txn(1'($urandom), 1'($urandom), len, $urandom, $urandom,
             stop, extra, 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI responder (slave) for the single-chip-select bus driven by spi_master; it is the other end of that link.
- Oversamples SCLK, CS and MOSI on the system clock. Shifts in 8/16/24/32-bit words MSB-first and drives MISO from a word latched at chip-select assertion.
- Supports all four CPOL/CPHA modes.
- Reports completion with a one-cycle rx_valid pulse, and early CS release with abort.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronisers for SCLK/CS/MOSI (legal 2..3)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
SCLK  in  1  SPI clock from master (asynchronous to clk)
CS  in  1  chip select, active-low (asynchronous)
MOSI  in  1  serial data from master
MISO  out  1  serial data to master
tx_data  in  32  word to send, right-justified; latched at CS assertion
rx_data  out  32  last completed received word, right-justified, upper unused bits 0
transaction_length  in  2  word length = 8*(transaction_length+1) bits; latched at CS assertion
CPOL  in  1  SCLK idle level; latched at CS assertion
CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge; latched at CS assertion
default_val  in  1  MISO level when not shifting
busy  out  1  high while a transaction is in progress
rx_valid  out  1  one-cycle pulse when rx_data updates
abort  out  1  one-cycle pulse when CS deasserts before the word completes

Behaviour:
- Reset values: MISO=default_val (combinational path), rx_data=0, busy=0, rx_valid=0, abort=0, state=IDLE. CS sync chain resets to 1, SCLK and MOSI chains reset to 0.
- Synchronisers: SYNC_STAGES flops per input plus one history flop. cs_fall, cs_rise and sclk_rise/sclk_fall are single-cycle pulses derived from the sync output and the history flop.
- Edge mapping: the leading edge is the rise when CPOL=0 and the fall when CPOL=1; the trailing edge is the other one.
  - Sample edge: leading when CPHA=0, trailing when CPHA=1.
  - Shift edge: the other one.
- Latency: a pin edge produces its internal pulse exactly SYNC_STAGES+1 clk later.
- Timing requirement on the master: SCLK half-period ≥ SYNC_STAGES+3 clk, and CS setup/hold to the first/last SCLK edge ≥ SYNC_STAGES+3 clk. Faster SCLK is unsupported.
- State IDLE:
  - busy=0, MISO=default_val, SCLK edges ignored.
  - On cs_fall: latch tx_data, length N, CPOL and CPHA; clear rx_shift and bit counters; tx_idx=N-1; go to ACTIVE.
- State ACTIVE (busy=1):
  - On each sample edge: rx_shift <= {rx_shift[30:0], MOSI_sync}; rx_cnt++.
  - When rx_cnt reaches N: rx_data <= rx_shift (including the bit just sampled); rx_valid=1 for one cycle; go to DONE.
  - CPHA=0: MISO=tx_lat[tx_idx] from entry to ACTIVE; tx_idx decrements on each trailing (shift) edge.
  - CPHA=1: MISO=default_val until the first leading edge, then tx_lat[tx_idx]. tx_idx decrements on every leading edge after the first.
  - cs_rise before rx_cnt reaches N: abort=1 for one cycle; rx_data unchanged; go to IDLE.
- State DONE (busy=1):
  - MISO holds the last bit, all SCLK edges are ignored, and further bits are not received.
  - On cs_rise: go to IDLE; no abort.
- Simultaneous events: an SCLK edge in the same cycle as cs_fall is ignored. If cs_rise coincides with the final sample edge, the word completes: rx_valid fires, abort does not.
- Reset mid-transaction: return to IDLE immediately with no pulses. If CS is still low after reset, no transaction starts until CS is seen high and then low.
- tx_data or configuration inputs changing during ACTIVE/DONE has no effect.

Test Plan:
1. CPOL=1, CPHA=0, length 0. Master sends 0xCA, slave tx_data=0xF2 (242), master SCLK half-period 8 clk → slave rx_data=0x000000CA with one rx_valid pulse; master receives 0xF2; busy falls after CS rises; abort stays 0.
2. CPOL=1, CPHA=0, length 3. Master sends 0x9602C5CA, slave tx_data=0x12345678 → rx_data=0x9602C5CA; master receives 0x12345678; exactly 32 samples.
3. All four CPOL/CPHA modes, length 1. Master sends 0xA55A, slave tx_data=0x3CC3 → both sides exchange correctly in every mode; MISO=default_val before the first leading edge when CPHA=1.
4. Length 2 with CS released after 10 bits → abort pulses once, rx_valid stays 0, rx_data keeps its previous value, state returns to IDLE. The next full transfer of 0xABCDEF succeeds.
5. rst asserted mid-word with CS held low → outputs return to reset values. Further SCLK edges are ignored until CS goes high, then low; the following 8-bit transfer of 0x5E succeeds.
6. 12 extra SCLK pulses after an 8-bit word, before CS rises → rx_data equals the first 8 bits only; a single rx_valid pulse; MISO constant after the word.
